// File: rtl/i2c_slave_single_byte.sv
// i2c_slave_single_byte
//   Minimal I2C target that accepts one data byte per write transfer and
//   returns one byte per read transfer. SCL is only observed (no clock
//   stretching); SDA is open-drain, either pulled low or released.
//
// Ports
//   i_Clk       system clock, all logic on the rising edge
//   i_Rst_n     asynchronous active-low reset
//   i_Tx_Byte   byte returned to the master, latched when the address ACK ends
//   o_Rx_Byte   last byte written by the master
//   o_Rx_Valid  one-cycle pulse when o_Rx_Byte is updated
//   o_Rd_Req    one-cycle pulse when a matching read address is accepted
//   o_Busy      high from a detected START until a detected STOP
//   io_scl      I2C clock line (input only)
//   io_sda      I2C data line (open-drain)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus ignored until a START
// ADDR      | shifting in 7 address bits and the R/W bit
// ADDR_ACK  | pulling SDA low for the address acknowledge
// WR_DATA   | shifting in the single data byte
// WR_ACK    | pulling SDA low for the data acknowledge
// RD_DATA   | driving the read byte MSB-first
// RD_ACK    | SDA released, master's ACK/NACK sampled
// WAIT_STOP | SDA released, everything ignored until STOP or START

module i2c_slave_single_byte #(
    parameter logic [6:0] SLAVE_ADDR = 7'h51
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [7:0] i_Tx_Byte,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Valid,
    output logic       o_Rd_Req,
    output logic       o_Busy,
    input  logic       io_scl,
    inout  wire        io_sda
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    // Two synchronizer stages plus one history stage per line. Resetting
    // them to 1 matches an idle bus, so no false edge appears after reset.
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= io_scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= io_sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;

    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign bus_start =  scl_s2 & ~sda_s2 &  sda_d;
    assign bus_stop  =  scl_s2 &  sda_s2 & ~sda_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;   // 8th bit of the current byte seen
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_byte_d;
    logic       rx_valid_d, rd_req_d, busy_d;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            shift_q     <= 8'h00;
            tx_q        <= 8'hFF;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            o_Rx_Byte   <= 8'h00;
            o_Rx_Valid  <= 1'b0;
            o_Rd_Req    <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            o_Rx_Byte   <= rx_byte_d;
            o_Rx_Valid  <= rx_valid_d;
            o_Rd_Req    <= rd_req_d;
            o_Busy      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        rx_byte_d   = o_Rx_Byte;
        rx_valid_d  = 1'b0;
        rd_req_d    = 1'b0;
        busy_d      = o_Busy;

        case (state_q)
            ST_ADDR: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s2};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_d = 1'b1;
                    end
                end else if (scl_fall && byte_done_q) begin
                    byte_done_d = 1'b0;
                    if (shift_q[7:1] == SLAVE_ADDR) begin
                        state_d  = ST_ADDR_ACK;
                        sda_oe_d = 1'b1;
                        rw_d     = shift_q[0];
                        rd_req_d = shift_q[0];
                    end else begin
                        state_d  = ST_WAIT_STOP;
                        sda_oe_d = 1'b0;
                    end
                end
            end

            ST_ADDR_ACK: begin
                if (scl_fall) begin
                    bit_cnt_d   = 3'd0;
                    byte_done_d = 1'b0;
                    if (rw_q) begin
                        state_d  = ST_RD_DATA;
                        tx_d     = i_Tx_Byte;
                        sda_oe_d = ~i_Tx_Byte[7];
                    end else begin
                        state_d  = ST_WR_DATA;
                        sda_oe_d = 1'b0;
                    end
                end
            end

            ST_WR_DATA: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s2};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_d = 1'b1;
                        rx_byte_d   = {shift_q[6:0], sda_s2};
                        rx_valid_d  = 1'b1;
                    end
                end else if (scl_fall && byte_done_q) begin
                    state_d     = ST_WR_ACK;
                    byte_done_d = 1'b0;
                    sda_oe_d    = 1'b1;
                end
            end

            ST_WR_ACK: begin
                if (scl_fall) begin
                    state_d  = ST_WAIT_STOP;
                    sda_oe_d = 1'b0;
                end
            end

            ST_RD_DATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_d = 1'b1;
                    end
                end else if (scl_fall) begin
                    if (byte_done_q) begin
                        state_d     = ST_RD_ACK;
                        byte_done_d = 1'b0;
                        sda_oe_d    = 1'b0;
                    end else begin
                        // Next bit goes out on this fall; a 1 releases the line.
                        tx_d     = {tx_q[6:0], 1'b1};
                        sda_oe_d = ~tx_q[6];
                    end
                end
            end

            ST_RD_ACK: begin
                // Whatever the master answers, only one byte is ever served.
                if (scl_rise) begin
                    state_d = ST_WAIT_STOP;
                end
            end

            ST_WAIT_STOP: begin
                sda_oe_d = 1'b0;
            end

            default: begin
                sda_oe_d = 1'b0;
            end
        endcase

        // Bus conditions override every state. The rx outputs are left
        // alone so a data byte completing alongside a START is not lost.
        if (bus_start) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
        end else if (bus_stop) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end
    end

    assign io_sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_single_byte.sv
// Bench for i2c_slave_single_byte: a bit-level I2C master drives the bus,
// a transfer-level model predicts ACKs, read data and written bytes, and a
// monitor pops expected o_Rx_Valid / o_Rd_Req events from queues.
`timescale 1ns/1ps

module tb_i2c_slave_single_byte;

    localparam int         Q    = 10;       // i_Clk cycles per SCL quarter
    localparam logic [6:0] ADDR = 7'h51;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       rx_valid, rd_req, busy;
    logic       scl;
    logic       m_sda_low;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    i2c_slave_single_byte #(.SLAVE_ADDR(ADDR)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Tx_Byte  (tx_byte),
        .o_Rx_Byte  (rx_byte),
        .o_Rx_Valid (rx_valid),
        .o_Rd_Req   (rd_req),
        .o_Busy     (busy),
        .io_scl     (scl),
        .io_sda     (sda_bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         dut_low_cnt = 0;
    logic [7:0] exp_rx_q[$];
    int         exp_rd_q[$];
    logic [7:0] model_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output pulse must match a queued expectation.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid) begin
            n_checks++;
            if (exp_rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_valid_unexpected: got pulse with byte %02h, required no pulse", rx_byte);
            end else begin
                e = exp_rx_q.pop_front();
                if (rx_byte !== e) begin
                    n_fail++;
                    $display("FAIL rx_byte: got %02h, required %02h", rx_byte, e);
                end
            end
        end
        if (rd_req) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_req_unexpected: got pulse, required no pulse");
            end else begin
                void'(exp_rd_q.pop_front());
            end
        end
    end

    // Counts cycles where the target, not the master, holds SDA low.
    always begin
        @(negedge clk);
        #2;
        if (!m_sda_low && sda_bus === 1'b0) dut_low_cnt++;
    end

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b1; wait_q(Q);
        scl = 1'b0;       wait_q(Q);
    endtask

    task automatic bus_rep_start();
        m_sda_low = 1'b0; wait_q(Q);
        scl = 1'b1;       wait_q(Q);
        m_sda_low = 1'b1; wait_q(Q);
        scl = 1'b0;       wait_q(Q);
    endtask

    // o_Busy must still be high two cycles after the SDA rise and low on the third.
    task automatic bus_stop(input logic exp_busy);
        m_sda_low = 1'b1; wait_q(Q);
        scl = 1'b1;       wait_q(Q);
        m_sda_low = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("busy_before_stop_acts", busy, exp_busy);
        @(posedge clk); @(negedge clk);
        check("busy_after_stop", busy, 0);
        wait_q(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_q(Q);
        scl = 1'b1;     wait_q(Q);
        scl = 1'b0;     wait_q(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_q(Q);
        scl = 1'b1;       wait_q(Q / 2);
        b = sda_bus;      wait_q(Q / 2);
        scl = 1'b0;       wait_q(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    // One address phase plus nbytes data bytes, checked against the
    // transfer-level rules: only the first byte after a matching address
    // is served, everything else is NACKed or reads as FF.
    task automatic segment(input logic [6:0] a, input logic rw, input int nbytes,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic last_ack);
        logic       match, ack;
        logic [7:0] d, got, exp, tx_exp;
        match  = (a == ADDR);
        tx_exp = tx_byte;
        if (match && rw) exp_rd_q.push_back(1);
        write_byte({a, rw}, ack);
        check("addr_ack", ack, match);
        // Later changes to i_Tx_Byte must not reach the bus.
        tx_byte = 8'($urandom);
        for (int k = 0; k < nbytes; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            if (!rw) begin
                if (match && k == 0) begin
                    exp_rx_q.push_back(d);
                    model_rx = d;
                end
                write_byte(d, ack);
                check("wr_data_ack", ack, match && k == 0);
            end else begin
                exp = (match && k == 0) ? tx_exp : 8'hFF;
                read_byte(got, (k < nbytes - 1) ? 1'b1 : last_ack);
                check("rd_data", got, exp);
            end
        end
    endtask

    initial begin
        logic       ack, b;
        logic [6:0] a;
        logic [7:0] t;
        int         low_snap, nseg;

        rst_n     = 1'b0;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        tx_byte   = 8'h00;
        model_rx  = 8'h00;
        wait_q(5);
        check("reset_rx_byte",  rx_byte, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rd_req",   rd_req, 0);
        check("reset_busy",     busy, 0);
        check("reset_sda",      sda_bus, 1);
        rst_n = 1'b1;
        wait_q(5);

        // Write 0x51/W, 0xAC
        bus_start();
        check("busy_after_start", busy, 1);
        segment(ADDR, 1'b0, 1, 8'hAC, 8'h00, 8'h00, 1'b0);
        bus_stop(1'b1);
        check("rx_byte_after_write", rx_byte, model_rx);

        // Read 0x51/R of 0x3C with master NACK
        tx_byte = 8'h3C;
        bus_start();
        segment(ADDR, 1'b1, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        bus_stop(1'b1);

        // Wrong address: the target never touches SDA
        low_snap = dut_low_cnt;
        bus_start();
        segment(7'h50, 1'b0, 1, 8'h11, 8'h00, 8'h00, 1'b0);
        bus_stop(1'b1);
        check("no_drive_on_mismatch", dut_low_cnt, low_snap);
        check("rx_byte_after_mismatch", rx_byte, model_rx);

        // Write 0x12, repeated START, read 0xA5
        bus_start();
        segment(ADDR, 1'b0, 1, 8'h12, 8'h00, 8'h00, 1'b0);
        tx_byte = 8'hA5;
        bus_rep_start();
        segment(ADDR, 1'b1, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        bus_stop(1'b1);
        check("rx_byte_after_rep_start", rx_byte, 8'h12);

        // Two data bytes: the second is NACKed and dropped
        bus_start();
        segment(ADDR, 1'b0, 2, 8'h01, 8'h02, 8'h00, 1'b0);
        bus_stop(1'b1);
        check("rx_byte_two_bytes", rx_byte, 8'h01);

        // Randomized transfers
        for (int it = 0; it < 16; it++) begin
            bus_start();
            nseg = $urandom_range(1, 2);
            for (int s = 0; s < nseg; s++) begin
                if (s > 0) bus_rep_start();
                a       = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
                tx_byte = 8'($urandom);
                segment(a, 1'($urandom), $urandom_range(1, 3),
                        8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            end
            bus_stop(1'b1);
            check("rx_byte_random", rx_byte, model_rx);
        end

        // Reset while the target drives read bit 3 (0) low
        t       = 8'hE7;
        tx_byte = t;
        exp_rd_q.push_back(1);
        bus_start();
        write_byte({ADDR, 1'b1}, ack);
        check("addr_ack_pre_reset", ack, 1);
        for (int i = 7; i > 3; i--) begin
            read_bit(b);
            check("rd_bit_pre_reset", b, t[i]);
        end
        check("bit3_driven_low", sda_bus, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("sda_released_async", sda_bus, 1);
        check("busy_cleared_async", busy, 0);
        model_rx = 8'h00;
        wait_q(3);
        rst_n = 1'b1;
        check("rx_byte_after_reset", rx_byte, 8'h00);

        // Bus activity without a START is ignored
        low_snap = dut_low_cnt;
        write_byte({ADDR, 1'b0}, ack);
        check("no_ack_without_start", ack, 0);
        write_byte(8'h5A, ack);
        check("no_ack_data_without_start", ack, 0);
        check("idle_busy_without_start", busy, 0);
        check("idle_no_drive", dut_low_cnt, low_snap);
        m_sda_low = 1'b0;
        scl = 1'b1;
        wait_q(Q);

        // Recovery transfer
        tx_byte = 8'($urandom);
        bus_start();
        segment(ADDR, 1'b1, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        bus_stop(1'b1);

        wait_q(5);
        check("rx_queue_drained", exp_rx_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_single_byte.md
I2C_SLAVE_SINGLE_BYTE -- requirements
Module: i2c_slave_single_byte

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h51: 7-bit address this target answers to.
REQ-002 i_Clk  input  1  system clock, 50 MHz nominal; all logic on rising edge.
REQ-003 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_Tx_Byte  input  8  byte returned on a read transfer; sampled as defined in REQ-019.
REQ-005 o_Rx_Byte  output  8  last byte written by the master.
REQ-006 o_Rx_Valid  output  1  one-cycle pulse when o_Rx_Byte is updated.
REQ-007 o_Rd_Req  output  1  one-cycle pulse when a matching read address is accepted.
REQ-008 o_Busy  output  1  high from the detected START until the detected STOP.
REQ-009 io_scl  input  1  I2C clock line; observed only, never driven; no clock stretching.
REQ-010 io_sda  inout  1  open-drain data line; driven 1'b0 or released to 1'bz, never driven 1.

Function
REQ-011 io_scl and io_sda SHALL each pass through a 2-flop synchronizer, plus one history flop for edge detection.
- Every bus event acts exactly 3 i_Clk cycles after the pin change.
- Correct operation requires SCL high and low phases each >= 8 i_Clk cycles.
REQ-012 START SHALL be detected as a synchronized SDA fall while synchronized SCL is high; STOP SHALL be detected as a synchronized SDA rise while SCL is high.
REQ-013 States SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-014 A START in any state SHALL force ADDR, clear the bit counter and release SDA; this covers repeated START.
REQ-015 A STOP in any state SHALL force IDLE and release SDA.
REQ-016 In ADDR, the block SHALL shift SDA MSB-first on each SCL rise; 7 address bits are followed by the R/W bit.
- Address match: go to ADDR_ACK on the next SCL fall.
- Mismatch: go to WAIT_STOP with SDA released (NACK).
REQ-017 In ADDR_ACK, SDA SHALL be pulled low from the SCL fall after bit 8 until the SCL fall after the 9th clock.
REQ-018 Write path (R/W=0), after ADDR_ACK:
- WR_DATA: shift 8 bits on SCL rises.
- On the 8th rise: update o_Rx_Byte and pulse o_Rx_Valid.
- WR_ACK: drive ACK as in REQ-017.
- Then go to WAIT_STOP.
- Further bytes in the same transfer are NACKed, and o_Rx_Byte is not updated by them.
REQ-019 Read path (R/W=1):
- o_Rd_Req SHALL pulse in the cycle ADDR_ACK is entered.
- i_Tx_Byte SHALL be latched at the SCL fall ending ADDR_ACK.
- RD_DATA: drive bits MSB-first, each changed only on an SCL fall; a 0 bit pulls SDA low, a 1 bit releases SDA.
REQ-020 After the 8th read bit, SDA SHALL be released for RD_ACK, and the master's bit SHALL be sampled on the SCL rise.
- Master NACK or ACK: go to WAIT_STOP.
- In both cases no further data is driven, so extra reads return 8'hFF.
REQ-021 SDA SHALL change only while synchronized SCL is low, except for the releases on START/STOP forced by REQ-014 and REQ-015.
REQ-022 If o_Rx_Valid and a START occur in the same cycle, both SHALL take effect.
REQ-023 The bit counter SHALL be 3 bits wide and wrap 7->0 at each byte boundary.

Reset
REQ-024 While i_Rst_n is low, the block SHALL be in IDLE with io_sda = 1'bz.
- o_Rx_Byte = 8'h00; o_Rx_Valid, o_Rd_Req and o_Busy = 0.
- Synchronizer and history flops = 1.
REQ-025 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously).
REQ-026 After reset deasserts, the block SHALL ignore the bus until the next START.

Verification
REQ-027 Write 0x51/W, data 0xAC, STOP -> ACK on both 9th clocks; o_Rx_Byte=0xAC; o_Rx_Valid pulses once; o_Busy falls 3 cycles after STOP.
REQ-028 Read 0x51/R with i_Tx_Byte=0x3C, master NACK, STOP -> one o_Rd_Req pulse; SDA bits 0,0,1,1,1,1,0,0; IDLE after STOP.
REQ-029 Address 0x50/W, data 0x11 -> SDA never driven low; o_Rx_Valid stays 0; o_Rx_Byte unchanged.
REQ-030 Write 0x51/W, data 0x12, repeated START, 0x51/R with i_Tx_Byte=0xA5 -> o_Rx_Byte=0x12; master reads 0xA5.
REQ-031 Write 0x51/W, then 0x01 and 0x02 -> 0x01 ACKed, 0x02 NACKed; o_Rx_Byte=0x01.
REQ-032 i_Rst_n pulled low while driving read bit 3 low -> io_sda = z within the same cycle; no output activity until a new START.
